// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_detector
// Description : Serial bit-pattern detector with a runtime-programmable
//               pattern and don't-care mask. Overlapping or non-overlapping
//               matching is selectable. Bits are qualified by in_valid, and
//               matches are tallied in a saturating counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PAT_W        pattern length in bits (2..16)
//   CNT_W        width of the match counter
// Ports
//   clk          in   1      rising-edge clock
//   reset_n      in   1      synchronous active-low reset
//   cfg_load     in   1      latch pattern/mask/overlap and restart detection
//   cfg_pattern  in   PAT_W  target pattern, MSB is the first bit received
//   cfg_mask     in   PAT_W  1 = compare bit, 0 = don't care
//   cfg_overlap  in   1      1 = overlapping matches, 0 = non-overlapping
//   clr_cnt      in   1      clear the match counter
//   in_valid     in   1      in_bit is valid this cycle
//   in_bit       in   1      serial data bit
//   match        out  1      registered one-cycle match pulse
//   match_cnt    out  CNT_W  saturating match count
//   armed        out  1      history window holds PAT_W fresh bits
// ============================================================================
module seq_pattern_detector #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             clr_cnt,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  // The fill counter must be able to represent the value PAT_W itself.
  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] c_fill_thr  = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};

  // Configuration registers
  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_mask;
  logic              r_ovl;

  // Bit history. Only the newest PAT_W-1 bits need to be kept, because the
  // bit arriving this cycle completes the comparison window.
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;

  logic              r_match;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_armed;

  // Next-state wires
  logic [PAT_W-1:0]  w_win;
  logic              w_accept;
  logic              w_hit;
  logic [PAT_W-2:0]  w_hist_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign w_win = {r_hist, in_bit};

  // A bit offered in the same cycle as cfg_load is discarded. It can
  // therefore neither complete a match nor bump the counter.
  assign w_accept = in_valid & ~cfg_load;

  assign w_hit = w_accept
               & (r_fill >= c_fill_thr)
               & (((w_win ^ r_pat) & r_mask) == '0);

  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    if (cfg_load) begin
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (in_valid) begin
      w_hist_nxt = w_win[PAT_W-2:0];
      if (w_hit && !r_ovl) begin
        // Non-overlap: every bit of the next match must be new.
        w_fill_nxt = '0;
      end else if (r_fill != c_fill_full) begin
        w_fill_nxt = r_fill + FILL_W'(1);
      end
    end
  end

  // When a clear and a hit happen in the same cycle, the hit survives the
  // clear, so no event is lost.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr_cnt) begin
      w_cnt_nxt = w_hit ? CNT_W'(1) : '0;
    end else if (w_hit && (r_cnt != c_cnt_max)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pat   <= '0;
      r_mask  <= '1;
      r_ovl   <= 1'b1;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      if (cfg_load) begin
        r_pat  <= cfg_pattern;
        r_mask <= cfg_mask;
        r_ovl  <= cfg_overlap;
      end
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_match <= w_hit;
      r_cnt   <= w_cnt_nxt;
      r_armed <= (w_fill_nxt == c_fill_full);
    end
  end

  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign armed     = r_armed;

endmodule
`default_nettype wire
